warp_issue: RTL and testbench
=============================

# warp_issue

Consumer-side companion to `warp_table`. It pops warp entries from the table and holds them in a 2-entry skid buffer that absorbs the table's one-cycle read latency. It presents them to the fetch stage on a valid/ready handshake, and writes yielded warps back into the table. It sits between `warp_table` and the fetch stage and is the table's only reader and only writer.

## Interface
- `DATA_W`, 44, warp-table entry width: `{warp_id[43:40], mask[39:32], pc[31:0]}`.
- `BUF_DEPTH`, 2, skid-buffer entries; fixed at 2 in this revision.
- `clk` in 1: single clock, all logic rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `halt` in 1: when high, no new table reads are started.
- `wt_read_en` out 1: table pop request.
- `wt_read_data` in 44: table data; meaningful only with `wt_read_valid`.
- `wt_read_valid` in 1: high the cycle after an accepted `wt_read_en`.
- `wt_fifo_empty` in 1: table empty flag.
- `wt_write_en` out 1: table push.
- `wt_write_data` out 44: push data.
- `wt_fifo_full` in 1: table full flag.
- `issue_valid` out 1: head entry valid toward fetch.
- `issue_ready` in 1: fetch accepts.
- `issue_warp_id` out 4, `issue_mask` out 8, `issue_pc` out 32: head entry fields.
- `yield_valid` in 1: warp returning for requeue.
- `yield_ready` out 1: requeue accepted this cycle.
- `yield_data` in 44: returning entry, same format.

## Operation
- Reset values: all outputs 0. Buffer is empty; in-flight counter `inflight` is 0.
- Read issue
  - `wt_read_en = !halt && !wt_fifo_empty && (occupancy + inflight + pop_now_credit) <= BUF_DEPTH - 1`.
  - Here `pop_now_credit` is 0; no credit is taken for a same-cycle issue handshake.
  - At most one read is outstanding; `inflight` is 1 bit.
- Read return
  - Cycle after `wt_read_en`: `inflight` clears.
  - If `wt_read_valid`, `wt_read_data` is written at the buffer tail.
  - If `wt_read_valid` is 0 (table went empty or was stale), the return is silently dropped and no error is raised.
- Issue: the buffer head drives `issue_*`. `issue_valid = occupancy != 0`. The head pops when `issue_valid && issue_ready`.
- Simultaneous pop and push
  - Occupancy is unchanged.
  - Ordering is preserved: the returning entry goes behind the remaining entry.
- Requeue
  - `yield_ready = !wt_fifo_full`.
  - On `yield_valid && yield_ready`: `wt_write_en=1` and `wt_write_data=yield_data`, combinationally in the same cycle.
  - A yield write and a read in the same cycle are both allowed; the table supports concurrent push/pop.
- Halt
  - Blocks only new `wt_read_en`.
  - An in-flight return is still captured.
  - Buffered entries keep issuing.
- Reset mid-operation: buffer and `inflight` clear immediately. An entry in flight from the table is lost, and the table owner accounts for it.

## Timing
- Table-to-issue latency
  - Entry popped at `wt_read_en` cycle N appears on `issue_*` in cycle N+2.
  - It is registered into the buffer at the N+1 edge; the buffer output is the registered head.
- Sustained throughput: one issue every 2 cycles, due to the single outstanding read.
- Full-rate back-pressure: while `issue_ready=0`, occupancy reaches 2 and `wt_read_en` stays 0.
- `issue_*` is stable while `issue_valid && !issue_ready`.
- `yield_ready` and `wt_write_en` are combinational from `wt_fifo_full`/`yield_valid`, with zero latency.

## Structure
- Shared package `warp_pkg`:
  - `warp_entry_t` packed struct `{warp_id, mask, pc}`.
  - Constants `WARP_ID_W=4`, `MASK_W=8`, `PC_W=32`, `WT_DATA_W=44`.
- One sub-module, `warp_skid_buf`: 2-entry register FIFO with push/pop/occupancy, head output, and pass-through ordering.
- Top-level holds the read-credit logic and the requeue path.

## Test plan
- Reset with the table empty → `wt_read_en`, `issue_valid`, `wt_write_en` all 0. Release `rst_n`: `wt_read_en` stays 0 while `wt_fifo_empty=1`.
- Table holds two entries (`warp_id` 3, pc `0x100`; `warp_id` 5, pc `0x200`), `issue_ready=1` → issues in order, first at N+2 and second at N+4. `wt_read_en` then drops once empty.
- `issue_ready=0` with 4 entries in the table → exactly 2 pops, occupancy 2, `wt_read_en` then 0. Raise `issue_ready` → the remaining entries drain in order.
- Read returns `wt_read_valid=0` (table emptied) → nothing enqueued, `issue_valid` stays 0, `inflight` cleared.
- `yield_valid=1`, `yield_data=0x7_FF_0000_0040`, `wt_fifo_full=0` → same-cycle `wt_write_en=1` with matching data. Same with `wt_fifo_full=1` → `yield_ready=0`, `wt_write_en=0`.
- `halt=1` asserted in the cycle of a read → that return is still issued and no further `wt_read_en`. Assert `rst_n=0` mid-stream → all outputs 0 asynchronously.

Source files
------------

// File: rtl/warp_pkg.sv
// Shared warp-table entry layout and field widths.
// No logic; types and constants only.
// No handshake of its own; used by the table's reader/writer blocks.
package warp_pkg;

    localparam int WARP_ID_W = 4;
    localparam int MASK_W    = 8;
    localparam int PC_W      = 32;
    localparam int WT_DATA_W = WARP_ID_W + MASK_W + PC_W;

    typedef struct packed {
        logic [WARP_ID_W-1:0] warp_id;
        logic [MASK_W-1:0]    mask;
        logic [PC_W-1:0]      pc;
    } warp_entry_t;

endpackage

// File: rtl/warp_skid_buf.sv
// Two-entry register FIFO; head is always the oldest entry.
// Latency: push visible at head the cycle after the push edge.
// Backpressure: pushes into a full buffer without a same-cycle pop are ignored.
module warp_skid_buf #(
    parameter int DATA_W = 44
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [1:0]        occupancy,
    output logic              not_empty
);

    logic [DATA_W-1:0] slot0;
    logic [DATA_W-1:0] slot1;
    logic [1:0]        occ;
    logic              do_pop;
    logic              do_push;

    assign do_pop  = pop && (occ != 2'd0);
    assign do_push = push && ((occ != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (occ == 2'd0) slot0 <= push_data;
                    else             slot1 <= push_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    // Returning entry lands behind whatever survives the pop.
                    if (occ == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head      = slot0;
    assign occupancy = occ;
    assign not_empty = (occ != 2'd0);

endmodule

// File: rtl/warp_issue.sv
// Pops warps from warp_table into a 2-entry skid buffer and issues them to fetch; requeues yields.
// Latency: table pop in cycle N issues in cycle N+2; yield write is combinational.
// Backpressure: reads stop when buffer+in-flight reach capacity; yield_ready follows table full.
module warp_issue
    import warp_pkg::*;
#(
    parameter int DATA_W    = 44,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt,
    output logic              wt_read_en,
    input  logic [DATA_W-1:0] wt_read_data,
    input  logic              wt_read_valid,
    input  logic              wt_fifo_empty,
    output logic              wt_write_en,
    output logic [DATA_W-1:0] wt_write_data,
    input  logic              wt_fifo_full,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [3:0]        issue_warp_id,
    output logic [7:0]        issue_mask,
    output logic [31:0]       issue_pc,
    input  logic              yield_valid,
    output logic              yield_ready,
    input  logic [DATA_W-1:0] yield_data
);

    localparam logic [2:0] CREDIT_LIMIT = 3'(BUF_DEPTH - 1);

    logic              inflight;
    logic [1:0]        occupancy;
    logic [2:0]        committed;
    logic              buf_push;
    logic              buf_pop;
    logic [DATA_W-1:0] head_raw;
    warp_entry_t       head_entry;

    // Slots already spoken for: buffered entries plus the one read in flight.
    assign committed  = {1'b0, occupancy} + {2'b00, inflight};

    // rst_n gating keeps combinational outputs at 0 while reset is asserted.
    assign wt_read_en = rst_n && !halt && !wt_fifo_empty && !inflight
                        && (committed <= CREDIT_LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= 1'b0;
        else        inflight <= wt_read_en;
    end

    // A return without wt_read_valid is dropped; inflight clears regardless.
    assign buf_push = inflight && wt_read_valid;
    assign buf_pop  = issue_valid && issue_ready;

    warp_skid_buf #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (buf_push),
        .push_data (wt_read_data),
        .pop       (buf_pop),
        .head      (head_raw),
        .occupancy (occupancy),
        .not_empty (issue_valid)
    );

    assign head_entry    = warp_entry_t'(head_raw);
    assign issue_warp_id = head_entry.warp_id;
    assign issue_mask    = head_entry.mask;
    assign issue_pc      = head_entry.pc;

    assign yield_ready   = rst_n && !wt_fifo_full;
    assign wt_write_en   = yield_valid && yield_ready;
    assign wt_write_data = wt_write_en ? yield_data : '0;

endmodule

// File: tb/tb_warp_issue.sv
// Self-checking bench for warp_issue: table + reference model in queues, randomized traffic.
module tb_warp_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        halt;
    logic        wt_read_en;
    logic [43:0] wt_read_data;
    logic        wt_read_valid;
    logic        wt_fifo_empty;
    logic        wt_write_en;
    logic [43:0] wt_write_data;
    logic        wt_fifo_full;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_warp_id;
    logic [7:0]  issue_mask;
    logic [31:0] issue_pc;
    logic        yield_valid;
    logic        yield_ready;
    logic [43:0] yield_data;

    always #5 clk = ~clk;

    warp_issue #(.DATA_W(44), .BUF_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt          (halt),
        .wt_read_en    (wt_read_en),
        .wt_read_data  (wt_read_data),
        .wt_read_valid (wt_read_valid),
        .wt_fifo_empty (wt_fifo_empty),
        .wt_write_en   (wt_write_en),
        .wt_write_data (wt_write_data),
        .wt_fifo_full  (wt_fifo_full),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_warp_id (issue_warp_id),
        .issue_mask    (issue_mask),
        .issue_pc      (issue_pc),
        .yield_valid   (yield_valid),
        .yield_ready   (yield_ready),
        .yield_data    (yield_data)
    );

    // Table contents, expected skid-buffer contents, and outstanding-read state.
    logic [43:0] table_q[$];
    logic [43:0] mq[$];
    bit          m_inflight;
    bit          pend_vld;
    logic [43:0] pend_dat;
    bit          stale;
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] rand_ent();
        logic [43:0] e;
        e[31:0]  = $urandom;
        e[43:32] = 12'($urandom);
        return e;
    endfunction

    function automatic bit exp_read_en();
        return rst_n && !halt && !wt_fifo_empty && !m_inflight
               && ((mq.size() + int'(m_inflight)) <= 1);
    endfunction

    function automatic bit exp_issue_valid();
        return rst_n && (mq.size() != 0);
    endfunction

    function automatic bit exp_yield_ready();
        return rst_n && !wt_fifo_full;
    endfunction

    task automatic reset_model();
        mq.delete();
        m_inflight = 1'b0;
        pend_vld   = 1'b0;
    endtask

    // Advance the model across a rising edge using the values present just before it.
    task automatic model_update();
        bit re;
        bit pop;
        bit wr;
        if (!rst_n) begin
            reset_model();
            return;
        end
        re  = exp_read_en();
        pop = exp_issue_valid() && issue_ready;
        wr  = yield_valid && exp_yield_ready();
        if (pop) void'(mq.pop_front());
        if (m_inflight && wt_read_valid) mq.push_back(wt_read_data);
        m_inflight = re;
        pend_vld   = 1'b0;
        if (re && table_q.size() > 0) begin
            pend_vld = 1'b1;
            pend_dat = table_q.pop_front();
        end
        if (wr) table_q.push_back(yield_data);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
        wt_read_valid = pend_vld;
        wt_read_data  = pend_vld ? pend_dat : rand_ent();
        wt_fifo_empty = stale ? 1'b0 : (table_q.size() == 0);
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        chk("wt_read_en", 64'(wt_read_en), 64'(exp_read_en()));
        chk("issue_valid", 64'(issue_valid), 64'(exp_issue_valid()));
        if (exp_issue_valid())
            chk("issue_head", 64'({issue_warp_id, issue_mask, issue_pc}), 64'(mq[0]));
        else if (!rst_n)
            chk("issue_head_rst", 64'({issue_warp_id, issue_mask, issue_pc}), 64'(0));
        chk("yield_ready", 64'(yield_ready), 64'(exp_yield_ready()));
        chk("wt_write_en", 64'(wt_write_en), 64'(yield_valid && exp_yield_ready()));
        if (yield_valid && exp_yield_ready())
            chk("wt_write_data", 64'(wt_write_data), 64'(yield_data));
    end

    initial begin
        logic [3:0] ids[$];
        int         pops;

        rst_n = 1'b0; halt = 1'b0; issue_ready = 1'b0;
        wt_read_data = '0; wt_read_valid = 1'b0; wt_fifo_empty = 1'b1; wt_fifo_full = 1'b0;
        yield_valid = 1'b0; yield_data = '0; stale = 1'b0;
        reset_model();

        // Reset state
        #2;
        chk("rst_read_en", 64'(wt_read_en), 64'(0));
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_write_en", 64'(wt_write_en), 64'(0));
        chk("rst_yield_ready", 64'(yield_ready), 64'(0));
        tick(); tick();
        rst_n = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("empty_no_read", 64'(wt_read_en), 64'(0));

        // Two entries, fetch always ready: issue at N+2 and N+4
        table_q.push_back({4'd3, 8'hFF, 32'h100});
        table_q.push_back({4'd5, 8'hFF, 32'h200});
        issue_ready = 1'b1;
        tick(); @(negedge clk);
        chk("order_rd_N", 64'(wt_read_en), 64'(1));
        tick(); @(negedge clk);
        chk("order_iv_N1", 64'(issue_valid), 64'(0));
        tick(); @(negedge clk);
        chk("order_iv_N2", 64'(issue_valid), 64'(1));
        chk("order_id_N2", 64'(issue_warp_id), 64'(3));
        chk("order_pc_N2", 64'(issue_pc), 64'(32'h100));
        tick(); @(negedge clk);
        chk("order_iv_N3", 64'(issue_valid), 64'(0));
        tick(); @(negedge clk);
        chk("order_id_N4", 64'(issue_warp_id), 64'(5));
        chk("order_pc_N4", 64'(issue_pc), 64'(32'h200));
        tick(); @(negedge clk);
        chk("order_rd_done", 64'(wt_read_en), 64'(0));

        // Back-pressure: exactly two pops, then drain in order
        issue_ready = 1'b0;
        for (int i = 1; i <= 4; i++) table_q.push_back({4'(i), 8'h0F, 32'(i * 16)});
        pops = 0;
        for (int i = 0; i < 8; i++) begin
            tick(); @(negedge clk);
            if (wt_read_en) pops++;
        end
        chk("bp_pops", 64'(pops), 64'(2));
        chk("bp_iv", 64'(issue_valid), 64'(1));
        chk("bp_rd_off", 64'(wt_read_en), 64'(0));
        issue_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            if (issue_valid) ids.push_back(issue_warp_id);
            tick(); @(negedge clk);
        end
        chk("bp_drain_cnt", 64'(ids.size()), 64'(4));
        for (int i = 0; i < 4 && i < ids.size(); i++)
            chk("bp_drain_id", 64'(ids[i]), 64'(i + 1));

        // Stale empty flag: return has no valid, nothing enqueued
        stale = 1'b1;
        tick(); @(negedge clk);
        chk("stale_rd", 64'(wt_read_en), 64'(1));
        tick(); @(negedge clk);
        chk("stale_iv1", 64'(issue_valid), 64'(0));
        tick(); @(negedge clk);
        chk("stale_iv2", 64'(issue_valid), 64'(0));
        chk("stale_rd_again", 64'(wt_read_en), 64'(1));
        stale = 1'b0;
        repeat (3) tick();

        // Requeue path, combinational
        yield_data = 44'h7_FF_0000_0040; wt_fifo_full = 1'b0; yield_valid = 1'b1;
        #1;
        chk("yield_we", 64'(wt_write_en), 64'(1));
        chk("yield_wd", 64'(wt_write_data), 64'(44'h7_FF_0000_0040));
        wt_fifo_full = 1'b1;
        #1;
        chk("yield_full_rdy", 64'(yield_ready), 64'(0));
        chk("yield_full_we", 64'(wt_write_en), 64'(0));
        tick();
        yield_valid = 1'b0; wt_fifo_full = 1'b0;
        repeat (6) tick();
        table_q.delete();
        repeat (4) tick();

        // Halt while a read is in flight
        table_q.push_back({4'd8, 8'hA5, 32'h800});
        table_q.push_back({4'd9, 8'hA5, 32'h900});
        table_q.push_back({4'd10, 8'hA5, 32'hA00});
        tick(); @(negedge clk);
        chk("halt_rd_N", 64'(wt_read_en), 64'(1));
        tick();
        halt = 1'b1;
        tick(); @(negedge clk);
        chk("halt_iv", 64'(issue_valid), 64'(1));
        chk("halt_id", 64'(issue_warp_id), 64'(8));
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            chk("halt_no_rd", 64'(wt_read_en), 64'(0));
        end
        halt = 1'b0;

        // Asynchronous reset mid-stream
        issue_ready = 1'b0; yield_valid = 1'b1; yield_data = rand_ent();
        repeat (4) tick();
        #3;
        rst_n = 1'b0;
        reset_model();
        #1;
        chk("arst_rd", 64'(wt_read_en), 64'(0));
        chk("arst_iv", 64'(issue_valid), 64'(0));
        chk("arst_we", 64'(wt_write_en), 64'(0));
        chk("arst_yr", 64'(yield_ready), 64'(0));
        chk("arst_pc", 64'(issue_pc), 64'(0));
        tick(); tick();
        rst_n = 1'b1; yield_valid = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            halt         = ($urandom % 8) == 0;
            issue_ready  = ($urandom % 4) != 0;
            yield_valid  = ($urandom % 3) == 0;
            wt_fifo_full = ($urandom % 5) == 0;
            yield_data   = rand_ent();
            stale        = (table_q.size() == 0) && (($urandom % 20) == 0);
            if ((($urandom % 3) == 0) && table_q.size() < 6) table_q.push_back(rand_ent());
            if (i == 1500) begin
                #2;
                rst_n = 1'b0;
                reset_model();
                tick();
                rst_n = 1'b1;
            end
        end

        yield_valid = 1'b0; halt = 1'b1; stale = 1'b0;
        repeat (6) tick();
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
